addr_drive_seq: RTL and testbench
=================================

// Module: addr_drive_seq
// PURPOSE
// - Downstream consumer of the driver control block's address FIFO. While a program is
//   active, pops address words and drives each address for its encoded hold count.
// - Returns the run-time address cycle count and hold-length histogram that the control
//   block exposes to software at 0x0104 and 0x1_1000+.
// PARAMETERS
// - ADDR_W             16   driven address width; word bits [31:16] (ADDR_W<=16)
// - ADDR_MON_CNT_RANGE 8    hold-count span of one histogram bin
// - ADDR_MON_CNT_SIZE  16   width of each histogram counter
// - MAX_ADDR_CYCLE_CNT 128  hold count covered by bins; NBINS = MAX/RANGE = 16
// PORTS
// - clk              in   1   clock
// - reset            in   1   synchronous, active-low reset
// - active_program   in   1   level from control block; 1 = sequence runs
// - addr_fifo_dout   in   32  FWFT FIFO head word: [31:16] address, [15:0] hold cycles
// - addr_fifo_empty  in   1   FIFO empty
// - addr_fifo_rd     out  1   pop strobe, 1 cycle per word
// - addr_ready       in   1   physical driver accepts addr_out this cycle
// - addr_out         out  ADDR_W  address currently driven
// - addr_valid       out  1   addr_out valid
// - addr_underrun    out  1   1-cycle pulse: word finished, FIFO empty, still active
// - addr_cycle_cnt   out  16  accepted drive cycles since program start, saturating
// - addr_mon_cnts    out  [NBINS-1:0][ADDR_MON_CNT_SIZE-1:0]  per-bin word counts
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, hold_rem 0, all bins 0.
// - FSM IDLE: on active_program=1 -> clear addr_cycle_cnt and all bins -> FETCH.
// - FETCH: !empty -> addr_fifo_rd=1; latch address into addr_out; hold_rem = max(hold,1);
//   update bin; -> DRIVE with addr_valid=1 next cycle.
//   empty -> stay, addr_valid=0.
// - DRIVE: addr_valid=1. Each cycle with addr_ready=1: hold_rem--, addr_cycle_cnt++.
//   No decrement while addr_ready=0.
// - Word end (hold_rem==1 && addr_ready):
//   - FIFO !empty -> pop the next word in the same cycle; no bubble.
//   - FIFO empty -> addr_underrun=1, addr_valid=0 next cycle -> FETCH.
// - Any state, active_program=0: -> IDLE next cycle; addr_valid and addr_fifo_rd go 0.
//   Remaining FIFO words are not popped. Counters and bins hold until the next start.
// - Hold count 0 is driven for 1 cycle and binned in bin 0.
// - Bin index = hold/ADDR_MON_CNT_RANGE; holds >= MAX_ADDR_CYCLE_CNT go to bin NBINS-1.
// - Bin counters and addr_cycle_cnt saturate at all-ones; no wrap.
// - active_program falling in the same cycle as a pop: the pop completes and the word is
//   binned, but it is not driven.
// - addr_fifo_rd is never asserted while addr_fifo_empty=1.
// - Reset mid-operation: immediate return to reset values. FIFO state is the FIFO's concern.
// STRUCTURE
// - Package addr_seq_pkg:
//   - state enum {IDLE, FETCH, DRIVE}
//   - word field localparams (ADDR_MSB/LSB, HOLD_MSB/LSB)
//   - function bin_idx(hold) with saturation to NBINS-1
// - Sub-module addr_mon_hist: NBINS saturating counters with inputs clr, inc, bin.
//   It drives addr_mon_cnts.
// - Top level holds the FSM, hold_rem and addr_cycle_cnt.
// TESTING
// - Push {0x1234,3},{0x5678,1}; active=1; ready=1
//   -> addr_out 0x1234 for 3 cycles, then 0x5678 for 1 cycle with no bubble.
//   -> underrun pulse, then cycle_cnt=4, bin0=2.
// - Word {0xAAAA,4}; ready toggles 1,0,1,0
//   -> word held for 8 cycles, cycle_cnt=4, no early pop.
// - Holds 0, 7, 8, 127, 128, 0xFFFF
//   -> bin0=2, bin1=1, bin15=3; hold 0 is driven for 1 cycle.
// - active=0 during DRIVE of {0x0F0F,10} after 5 cycles
//   -> valid=0 next cycle, no further rd, cycle_cnt=5 held.
//   -> a new start clears counts.
// - FIFO empty at start
//   -> FSM stays FETCH, rd=0, valid=0. A push then gives rd the next cycle.
// - reset=0 mid-DRIVE
//   -> next cycle all outputs 0, bins 0, FSM IDLE.
// - Preload bin0 with 0xFFFF words -> counter sticks at 0xFFFF.

Source files
------------

// File: rtl/addr_seq_pkg.sv
// Shared types, word layout and histogram geometry for the address drive sequencer.
package addr_seq_pkg;

    localparam int ADDR_W             = 16;
    localparam int ADDR_MON_CNT_RANGE = 8;
    localparam int ADDR_MON_CNT_SIZE  = 16;
    localparam int MAX_ADDR_CYCLE_CNT = 128;
    localparam int NBINS              = MAX_ADDR_CYCLE_CNT / ADDR_MON_CNT_RANGE;
    localparam int BIN_W              = $clog2(NBINS);
    localparam int HOLD_W             = 16;
    localparam int CYCLE_CNT_W        = 16;

    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 16;
    localparam int HOLD_MSB = 15;
    localparam int HOLD_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Long holds all land in the top bin so the histogram never loses a word.
    function automatic logic [BIN_W-1:0] bin_idx(input logic [HOLD_W-1:0] hold);
        logic [BIN_W-1:0] idx;
        if (hold >= HOLD_W'(MAX_ADDR_CYCLE_CNT)) begin
            idx = BIN_W'(NBINS - 1);
        end else begin
            idx = BIN_W'(hold / HOLD_W'(ADDR_MON_CNT_RANGE));
        end
        return idx;
    endfunction

endpackage

// File: rtl/addr_drive_seq_hist.sv
// Hold-length histogram: one saturating word counter per bin, cleared at program start.
module addr_mon_hist
    import addr_seq_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      clr,
    input  logic                                      inc,
    input  logic [BIN_W-1:0]                          bin,
    output logic [NBINS-1:0][ADDR_MON_CNT_SIZE-1:0]   cnts
);

    localparam logic [ADDR_MON_CNT_SIZE-1:0] CNT_MAX = {ADDR_MON_CNT_SIZE{1'b1}};

    // Bin counters: clear on start, bump the selected bin unless already saturated.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnts <= {(NBINS * ADDR_MON_CNT_SIZE){1'b0}};
        end else if (clr) begin
            cnts <= {(NBINS * ADDR_MON_CNT_SIZE){1'b0}};
        end else begin
            for (int i = 0; i < NBINS; i++) begin
                if (inc && (bin == BIN_W'(i)) && (cnts[i] != CNT_MAX)) begin
                    cnts[i] <= cnts[i] + {{(ADDR_MON_CNT_SIZE-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/addr_drive_seq.sv
// Pops address words from a FWFT FIFO and drives each address for its hold count,
// tracking accepted drive cycles and a hold-length histogram for software.
module addr_drive_seq
    import addr_seq_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      active_program,
    input  logic [31:0]                               addr_fifo_dout,
    input  logic                                      addr_fifo_empty,
    output logic                                      addr_fifo_rd,
    input  logic                                      addr_ready,
    output logic [ADDR_W-1:0]                         addr_out,
    output logic                                      addr_valid,
    output logic                                      addr_underrun,
    output logic [CYCLE_CNT_W-1:0]                    addr_cycle_cnt,
    output logic [NBINS-1:0][ADDR_MON_CNT_SIZE-1:0]   addr_mon_cnts
);

    localparam logic [CYCLE_CNT_W-1:0] CYCLE_MAX = {CYCLE_CNT_W{1'b1}};

    state_t              state_r;
    state_t              state_s;
    logic [HOLD_W-1:0]   hold_rem_r;
    logic [ADDR_W-1:0]   word_addr_s;
    logic [HOLD_W-1:0]   word_hold_s;
    logic                accept_s;
    logic                word_end_s;
    logic                pop_s;
    logic                start_s;

    assign word_addr_s = addr_fifo_dout[ADDR_LSB +: ADDR_W];
    assign word_hold_s = addr_fifo_dout[HOLD_MSB:HOLD_LSB];

    // Next state and pop strobe; a pop is never gated by active_program so a word
    // already being handed over completes even as the program stops.
    always_comb begin
        state_s    = state_r;
        pop_s      = 1'b0;
        start_s    = 1'b0;
        accept_s   = 1'b0;
        word_end_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (active_program) begin
                    start_s = 1'b1;
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                pop_s = !addr_fifo_empty;
                if (!active_program) begin
                    state_s = IDLE;
                end else if (!addr_fifo_empty) begin
                    state_s = DRIVE;
                end else begin
                    state_s = FETCH;
                end
            end
            DRIVE: begin
                accept_s   = addr_ready;
                word_end_s = addr_ready && (hold_rem_r == {{(HOLD_W-1){1'b0}}, 1'b1});
                pop_s      = word_end_s && !addr_fifo_empty;
                if (!active_program) begin
                    state_s = IDLE;
                end else if (word_end_s && addr_fifo_empty) begin
                    state_s = FETCH;
                end else begin
                    state_s = DRIVE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    assign addr_fifo_rd = pop_s;

    // FSM state, driven word, remaining hold, underrun pulse and cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= IDLE;
            hold_rem_r     <= {HOLD_W{1'b0}};
            addr_out       <= {ADDR_W{1'b0}};
            addr_valid     <= 1'b0;
            addr_underrun  <= 1'b0;
            addr_cycle_cnt <= {CYCLE_CNT_W{1'b0}};
        end else begin
            state_r       <= state_s;
            addr_valid    <= (state_s == DRIVE);
            addr_underrun <= active_program && word_end_s && addr_fifo_empty;
            if (pop_s) begin
                addr_out   <= word_addr_s;
                hold_rem_r <= (word_hold_s == {HOLD_W{1'b0}}) ?
                              {{(HOLD_W-1){1'b0}}, 1'b1} : word_hold_s;
            end else if (accept_s) begin
                hold_rem_r <= hold_rem_r - {{(HOLD_W-1){1'b0}}, 1'b1};
            end
            if (start_s) begin
                addr_cycle_cnt <= {CYCLE_CNT_W{1'b0}};
            end else if (accept_s && (addr_cycle_cnt != CYCLE_MAX)) begin
                addr_cycle_cnt <= addr_cycle_cnt + {{(CYCLE_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    addr_mon_hist u_hist (
        .clk   (clk),
        .reset (reset),
        .clr   (start_s),
        .inc   (pop_s),
        .bin   (bin_idx(word_hold_s)),
        .cnts  (addr_mon_cnts)
    );

endmodule

// File: tb/tb_addr_drive_seq.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT, expected beats and bins
// come from the word list, and a negedge monitor checks every accepted beat.
module tb_addr_drive_seq;

    localparam int AW    = addr_seq_pkg::ADDR_W;
    localparam int NB    = addr_seq_pkg::NBINS;
    localparam int CSZ   = addr_seq_pkg::ADDR_MON_CNT_SIZE;

    typedef struct {
        logic [15:0] addr;
        int          beats;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     active_program = 1'b0;
    logic [31:0]              addr_fifo_dout = 32'h0;
    logic                     addr_fifo_empty = 1'b1;
    logic                     addr_fifo_rd;
    logic                     addr_ready = 1'b0;
    logic [AW-1:0]            addr_out;
    logic                     addr_valid;
    logic                     addr_underrun;
    logic [15:0]              addr_cycle_cnt;
    logic [NB-1:0][CSZ-1:0]   addr_mon_cnts;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_valid = 0;
    int          n_rd    = 0;
    int          n_underrun = 0;
    bit          pop_req = 1'b0;
    logic [31:0] fifo_q[$];
    exp_t        sb[$];
    int          exp_bins[NB];
    int          exp_cnt = 0;

    addr_drive_seq dut (
        .clk             (clk),
        .reset           (reset),
        .active_program  (active_program),
        .addr_fifo_dout  (addr_fifo_dout),
        .addr_fifo_empty (addr_fifo_empty),
        .addr_fifo_rd    (addr_fifo_rd),
        .addr_ready      (addr_ready),
        .addr_out        (addr_out),
        .addr_valid      (addr_valid),
        .addr_underrun   (addr_underrun),
        .addr_cycle_cnt  (addr_cycle_cnt),
        .addr_mon_cnts   (addr_mon_cnts)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic update_fifo();
        addr_fifo_empty = (fifo_q.size() == 0);
        addr_fifo_dout  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    // A popped word is binned by hold length; bins saturate at 0xFFFF.
    task automatic model_bin(input int hold);
        int idx;
        idx = (hold >= 128) ? 15 : hold / 8;
        if (exp_bins[idx] != 65535) exp_bins[idx]++;
    endtask

    task automatic step();
        logic [31:0] w;
        @(posedge clk);
        #1;
        if (pop_req && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            model_bin(int'(w[15:0]));
        end
        pop_req = 1'b0;
        update_fifo();
    endtask

    task automatic push_word(input logic [15:0] addr, input int hold);
        int beats;
        beats = (hold == 0) ? 1 : hold;
        fifo_q.push_back({addr, 16'(hold)});
        sb.push_back('{addr: addr, beats: beats});
        exp_cnt = (exp_cnt + beats > 65535) ? 65535 : exp_cnt + beats;
        update_fifo();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NB; i++) exp_bins[i] = 0;
        exp_cnt = 0;
        n_valid = 0;
        n_rd = 0;
        n_underrun = 0;
    endtask

    task automatic start_program();
        step();
        active_program = 1'b1;
    endtask

    task automatic check_bins(input string tag);
        for (int i = 0; i < NB; i++)
            check($sformatf("%s_bin%0d", tag, i), int'(addr_mon_cnts[i]), exp_bins[i]);
    endtask

    // mode 0: ready always high, 1: alternating, 2: random.
    task automatic drain(input int mode, input int budget);
        int i;
        for (i = 0; i < budget && n_underrun == 0; i++) begin
            step();
            case (mode)
                0:       addr_ready = 1'b1;
                1:       addr_ready = (i % 2 == 0);
                default: addr_ready = 1'($urandom_range(0, 1));
            endcase
        end
        check("drain_done", int'(n_underrun > 0), 1);
        addr_ready = 1'b1;
        repeat (2) step();
        active_program = 1'b0;
        repeat (2) step();
    endtask

    task automatic check_done(input string tag);
        check({tag, "_sb_empty"}, sb.size(), 0);
        check({tag, "_underrun"}, n_underrun, 1);
        check({tag, "_cycle_cnt"}, int'(addr_cycle_cnt), exp_cnt);
        check_bins(tag);
    endtask

    // Monitor: checks each accepted beat against the head expected word.
    always @(negedge clk) begin
        check("rd_on_empty", int'(addr_fifo_rd & addr_fifo_empty), 0);
        pop_req = addr_fifo_rd;
        if (addr_fifo_rd) n_rd++;
        if (addr_valid) n_valid++;
        if (addr_underrun) n_underrun++;
        if (addr_valid && addr_ready) begin
            check("beat_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb[0];
                check("beat_addr", int'(addr_out), int'(e.addr));
                e.beats--;
                if (e.beats == 0) void'(sb.pop_front());
                else sb[0] = e;
            end
        end
    end

    initial begin
        int holds[6] = '{0, 7, 8, 127, 128, 65535};
        int pushed;

        // Reset state
        clear_model();
        repeat (3) step();
        check("rst_addr_out", int'(addr_out), 0);
        check("rst_valid", int'(addr_valid), 0);
        check("rst_rd", int'(addr_fifo_rd), 0);
        check("rst_underrun", int'(addr_underrun), 0);
        check("rst_cycle_cnt", int'(addr_cycle_cnt), 0);
        check_bins("rst");
        reset = 1'b1;
        step();

        // Two words, ready high: back-to-back with no bubble
        clear_model();
        push_word(16'h1234, 3);
        push_word(16'h5678, 1);
        addr_ready = 1'b1;
        start_program();
        drain(0, 50);
        check_done("basic");
        check("basic_valid_cycles", n_valid, 4);
        check("basic_rd", n_rd, 2);

        // Alternating ready stretches the word without an early pop
        clear_model();
        push_word(16'hAAAA, 4);
        start_program();
        drain(1, 50);
        check_done("toggle");
        check("toggle_valid_cycles", n_valid, 8);
        check("toggle_rd", n_rd, 1);

        // Bin boundaries; the last (0xFFFF) word is only partly driven
        clear_model();
        for (int i = 0; i < 6; i++) push_word(16'h1000 + 16'(i), holds[i]);
        start_program();
        for (int i = 0; i < 4000 && fifo_q.size() > 0; i++) begin
            step();
            addr_ready = 1'($urandom_range(0, 1));
        end
        check("bins_all_popped", fifo_q.size(), 0);
        repeat (3) step();
        active_program = 1'b0;
        repeat (2) step();
        check_bins("bins");
        check("bins_outstanding", sb.size(), 1);
        check("bins_underrun", n_underrun, 0);
        sb.delete();

        // Stop mid-word after 5 accepted beats
        clear_model();
        push_word(16'h0F0F, 10);
        push_word(16'h1111, 2);
        addr_ready = 1'b1;
        start_program();
        repeat (6) step();
        active_program = 1'b0;
        step();
        check("abort_valid", int'(addr_valid), 0);
        check("abort_rd", int'(addr_fifo_rd), 0);
        repeat (3) step();
        check("abort_cycle_cnt", int'(addr_cycle_cnt), 5);
        check("abort_rd_count", n_rd, 1);
        check("abort_fifo_left", fifo_q.size(), 1);
        check("abort_beats_left", (sb.size() > 0) ? sb[0].beats : -1, 5);
        fifo_q.delete();
        sb.delete();
        update_fifo();

        // Restart with an empty FIFO: counts cleared, waits in FETCH
        clear_model();
        start_program();
        repeat (3) step();
        check("empty_cycle_cnt", int'(addr_cycle_cnt), exp_cnt);
        check_bins("empty");
        check("empty_valid", int'(addr_valid), 0);
        check("empty_rd", int'(addr_fifo_rd), 0);
        push_word(16'h2222, 2);
        #1;
        check("empty_push_rd", int'(addr_fifo_rd), 1);
        drain(0, 50);
        check_done("late");

        // Reset in the middle of a long word
        clear_model();
        push_word(16'h3333, 20);
        start_program();
        repeat (6) step();
        reset = 1'b0;
        active_program = 1'b0;
        for (int i = 0; i < NB; i++) exp_bins[i] = 0;
        step();
        check("mrst_addr_out", int'(addr_out), 0);
        check("mrst_valid", int'(addr_valid), 0);
        check("mrst_underrun", int'(addr_underrun), 0);
        check("mrst_cycle_cnt", int'(addr_cycle_cnt), 0);
        check("mrst_rd", int'(addr_fifo_rd), 0);
        check_bins("mrst");
        reset = 1'b1;
        fifo_q.delete();
        sb.delete();
        update_fifo();
        repeat (2) step();
        check("mrst_idle_valid", int'(addr_valid), 0);

        // Saturation: 65537 zero-hold words into bin 0
        clear_model();
        addr_ready = 1'b1;
        push_word(16'($urandom), 0);
        push_word(16'($urandom), 0);
        pushed = 2;
        start_program();
        while (pushed < 65537) begin
            step();
            if (fifo_q.size() < 3) begin
                push_word(16'($urandom), 0);
                pushed++;
            end
        end
        drain(0, 100);
        check_done("sat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
